regfile_read_arbiter: RTL and testbench
=======================================

Name: regfile_read_arbiter

Overview:
- Shares the register file's two combinational read ports (operand lookup with ROB dependency bypass) among NUM_REQ issue-side requesters, such as the decoder/dispatch slots feeding the RS and LSB.
- Grants at most one requester per cycle using round-robin priority.
- Registers the operand pair plus dependency info into a single-entry response buffer with a valid/ready handshake.
- While a response is stalled, it keeps that response fresh by re-reading the register file every cycle.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- RID_W, 2, width of requester index; must satisfy 2^RID_W >= NUM_REQ.
- ROB_W, 4, ROB index width; equals `ROB_WIDTH_BIT.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global ready; when low, all state freezes
- flush_in  input  1  ROB clear / mispredict flush
- req_valid  input  NUM_REQ  per-requester lookup request
- req_rs1  input  5*NUM_REQ  packed rs1 ids; requester i occupies bits [5i+4:5i]
- req_rs2  input  5*NUM_REQ  packed rs2 ids
- req_ready  output  NUM_REQ  one-hot grant; request accepted when valid&ready at a clock edge
- rf_get_id1  output  5  register file read port 1 id
- rf_get_val1  input  32  port 1 value (already ROB-bypassed)
- rf_get_has_dep1  input  1  port 1 still waiting on ROB
- rf_get_dep1  input  ROB_W  port 1 producing ROB entry
- rf_get_id2, rf_get_val2, rf_get_has_dep2, rf_get_dep2  same as port 1, for port 2
- rsp_valid  output  1  response buffer holds a result
- rsp_ready  input  1  consumer takes the response at this edge
- rsp_rid  output  RID_W  index of the requester the response belongs to
- rsp_val1  output  32  operand 1 value
- rsp_has_dep1  output  1  operand 1 dependency flag
- rsp_dep1  output  ROB_W  operand 1 ROB tag
- rsp_val2, rsp_has_dep2, rsp_dep2  same as operand 1, for operand 2

Behaviour:
- Reset (rst_in low, asynchronous): rsp_valid=0; all rsp_* fields=0; round-robin pointer=0; held rs ids=0.
- Outputs are valid from the first edge after reset deassertion.
- Slot free condition: slot_free = !rsp_valid | rsp_ready.
- Grant condition: a grant occurs when rdy_in & !flush_in & slot_free & |req_valid.
- Arbitration: the first valid requester at or after ptr (wrapping modulo NUM_REQ) wins.
  - req_ready is one-hot on the winner, all zeros otherwise.
  - req_ready is combinational and may depend on req_valid.
- Read port drive, in priority order:
  - Grant cycle: rf_get_id1/2 = winner's rs1/rs2.
  - Else, if rsp_valid & !rsp_ready: rf_get_id1/2 = held rs1/rs2 (refresh).
  - Else: rf_get_id1/2 = 0.
- Capture (rdy_in high, no flush):
  - On grant: the response regs load rf_get_val/has_dep/dep for both ports, rsp_rid=winner, held ids=winner's rs ids, rsp_valid=1, ptr=(winner+1) mod NUM_REQ.
  - If no grant and the slot is drained (rsp_valid&rsp_ready): rsp_valid=0.
  - Refresh case: the val/has_dep/dep fields reload from the ports; rsp_rid and held ids are unchanged.
  - Refresh means an operand whose producer commits while the response is stalled shows has_dep=0 with the correct value, never a stale tag.
- x0 handling: if an operand id is 0, force val=0, has_dep=0, dep=0 regardless of port inputs.
- Latency and throughput: request accepted at edge N gives rsp_valid high after edge N. Sustained throughput is 1 response/cycle when rsp_ready is held high.
- Flush: at the edge with flush_in high and rdy_in high:
  - rsp_valid=0.
  - No grant that cycle (req_ready=0).
  - ptr unchanged.
  - Fields may keep stale data, but rsp_valid=0 masks them.
- rdy_in low:
  - req_ready=0, rf ids=0.
  - No register changes, including flush.
  - rsp_* outputs hold steady.
  - A consumer must not count a handshake while rdy_in is low.
- Simultaneous drain and grant: the new response replaces the old one at the same edge, with no bubble.
- Single requester continuously valid: it is granted every cycle the slot is free; the pointer still advances.

Test Plan:
- Reset and idle: rst_in low mid-operation with rsp_valid=1 -> rsp_valid drops immediately (asynchronously); after release with no requests, rf_get_id1/2=0 and req_ready=0.
- Single lookup: req_valid=001, rs1=5, rs2=0, rf port1 returns val=0x1234, has_dep=0 -> req_ready=001; next cycle rsp_valid=1, rsp_rid=0, rsp_val1=0x1234, rsp_val2=0, rsp_has_dep2=0.
- Round robin: req_valid=111 held, rsp_ready=1 -> grant order 0,1,2,0,...; rsp_rid sequence 0,1,2,0 on consecutive cycles with no bubbles.
- Stall refresh: response for rs1=7 captured with has_dep=1, dep=3; rsp_ready=0 for 3 cycles; the register file port changes to has_dep=0, val=0xBEEF in cycle 2 -> rf_get_id1=7 throughout, rsp_has_dep1=0 and rsp_val1=0xBEEF from the following cycle, rsp_rid unchanged, req_ready=000 during the stall.
- Flush: rsp_valid=1 and req_valid=010 with flush_in=1 -> req_ready=000; next cycle rsp_valid=0; the pointer value is preserved, so requester 1 is granted the cycle after the flush.
- Pause: rdy_in=0 for 2 cycles with requests pending and rsp_ready=1 -> req_ready=000, rsp fields frozen; arbitration resumes from the same pointer when rdy_in returns to 1.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
// Shares the register file's two combinational read ports among NUM_REQ
// issue-side requesters. One round-robin winner per cycle has its operand
// pair (value, dependency flag, ROB tag) captured into a single-entry
// response buffer with a valid/ready handshake. While the buffered response
// is stalled, its held register ids are re-read every cycle so a producer
// that commits during the stall is reflected as a resolved operand.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int RID_W   = 2,
  parameter int ROB_W   = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [5*NUM_REQ-1:0] req_rs1,
  input  logic [5*NUM_REQ-1:0] req_rs2,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [4:0]           rf_get_id1,
  input  logic [31:0]          rf_get_val1,
  input  logic                 rf_get_has_dep1,
  input  logic [ROB_W-1:0]     rf_get_dep1,
  output logic [4:0]           rf_get_id2,
  input  logic [31:0]          rf_get_val2,
  input  logic                 rf_get_has_dep2,
  input  logic [ROB_W-1:0]     rf_get_dep2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RID_W-1:0]     rsp_rid,
  output logic [31:0]          rsp_val1,
  output logic                 rsp_has_dep1,
  output logic [ROB_W-1:0]     rsp_dep1,
  output logic [31:0]          rsp_val2,
  output logic                 rsp_has_dep2,
  output logic [ROB_W-1:0]     rsp_dep2
);

  // Round-robin pointer: the requester index that has highest priority.
  logic [RID_W-1:0] ptr;
  // Register ids of the buffered response, used to refresh it while stalled.
  logic [4:0]       held_rs1;
  logic [4:0]       held_rs2;

  // Per-requester register ids unpacked from the flat request buses.
  logic [4:0] rs1_arr [NUM_REQ];
  logic [4:0] rs2_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rs1_arr[g] = req_rs1[5*g +: 5];
    assign rs2_arr[g] = req_rs2[5*g +: 5];
  end

  logic             slot_free;
  logic             grant;
  logic             win_found;
  logic [RID_W-1:0] win_idx;
  logic [RID_W-1:0] ptr_nxt;
  logic             refresh;

  int               cand_i;
  logic [RID_W-1:0] cand;

  assign slot_free = !rsp_valid || rsp_ready;
  assign grant     = rdy_in && !flush_in && slot_free && win_found;
  assign refresh   = rdy_in && rsp_valid && !rsp_ready;
  assign ptr_nxt   = (win_idx == RID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Find the first valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand_i    = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_i = int'(ptr) + k;
      if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
      cand = RID_W'(cand_i);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // One-hot grant on the winner.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  // Read port ids: the new winner first, else the stalled response's ids.
  always_comb begin
    rf_get_id1 = '0;
    rf_get_id2 = '0;
    if (grant) begin
      rf_get_id1 = rs1_arr[win_idx];
      rf_get_id2 = rs2_arr[win_idx];
    end else if (refresh) begin
      rf_get_id1 = held_rs1;
      rf_get_id2 = held_rs2;
    end
  end

  // x0 is hardwired zero with no dependency, whatever the ports report.
  logic [31:0]      val1_m, val2_m;
  logic             hd1_m, hd2_m;
  logic [ROB_W-1:0] dep1_m, dep2_m;

  // Mask port data for operand ids equal to x0.
  always_comb begin
    val1_m = rf_get_val1;
    hd1_m  = rf_get_has_dep1;
    dep1_m = rf_get_dep1;
    val2_m = rf_get_val2;
    hd2_m  = rf_get_has_dep2;
    dep2_m = rf_get_dep2;
    if (rf_get_id1 == 5'd0) begin
      val1_m = '0;
      hd1_m  = 1'b0;
      dep1_m = '0;
    end
    if (rf_get_id2 == 5'd0) begin
      val2_m = '0;
      hd2_m  = 1'b0;
      dep2_m = '0;
    end
  end

  // Response buffer, held ids and round-robin pointer; frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: the response buffer is a handful of flops, not a memory array,
    // so every field is cleared by the asynchronous reset.
    if (!rst_in) begin
      rsp_valid    <= 1'b0;
      rsp_rid      <= '0;
      rsp_val1     <= '0;
      rsp_has_dep1 <= 1'b0;
      rsp_dep1     <= '0;
      rsp_val2     <= '0;
      rsp_has_dep2 <= 1'b0;
      rsp_dep2     <= '0;
      held_rs1     <= '0;
      held_rs2     <= '0;
      ptr          <= '0;
    end else if (rdy_in) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (flush_in) begin
        rsp_valid <= 1'b0;
      end else if (grant) begin
        rsp_valid    <= 1'b1;
        rsp_rid      <= win_idx;
        held_rs1     <= rs1_arr[win_idx];
        held_rs2     <= rs2_arr[win_idx];
        rsp_val1     <= val1_m;
        rsp_has_dep1 <= hd1_m;
        rsp_dep1     <= dep1_m;
        rsp_val2     <= val2_m;
        rsp_has_dep2 <= hd2_m;
        rsp_dep2     <= dep2_m;
        ptr          <= ptr_nxt;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end else if (rsp_valid) begin
        rsp_val1     <= val1_m;
        rsp_has_dep1 <= hd1_m;
        rsp_dep1     <= dep1_m;
        rsp_val2     <= val2_m;
        rsp_has_dep2 <= hd2_m;
        rsp_dep2     <= dep2_m;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: a behavioural model of the
// arbiter and response slot is checked against the DUT on every falling edge,
// with directed scenarios carrying literal expectations followed by a
// randomized phase.
module tb_regfile_read_arbiter;

  localparam int N     = 3;
  localparam int RID_W = 2;
  localparam int ROB_W = 4;
  localparam int RSW   = 5 * N;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             rdy_in = 1'b1;
  logic             flush_in = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [RSW-1:0]   req_rs1 = '0;
  logic [RSW-1:0]   req_rs2 = '0;
  logic [N-1:0]     req_ready;
  logic [4:0]       rf_get_id1, rf_get_id2;
  logic [31:0]      rf_get_val1, rf_get_val2;
  logic             rf_get_has_dep1, rf_get_has_dep2;
  logic [ROB_W-1:0] rf_get_dep1, rf_get_dep2;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [RID_W-1:0] rsp_rid;
  logic [31:0]      rsp_val1, rsp_val2;
  logic             rsp_has_dep1, rsp_has_dep2;
  logic [ROB_W-1:0] rsp_dep1, rsp_dep2;

  // Register file contents as seen through the ROB bypass.
  logic [31:0]      rf_v  [32];
  logic             rf_hd [32];
  logic [ROB_W-1:0] rf_dp [32];

  assign rf_get_val1     = rf_v[rf_get_id1];
  assign rf_get_has_dep1 = rf_hd[rf_get_id1];
  assign rf_get_dep1     = rf_dp[rf_get_id1];
  assign rf_get_val2     = rf_v[rf_get_id2];
  assign rf_get_has_dep2 = rf_hd[rf_get_id2];
  assign rf_get_dep2     = rf_dp[rf_get_id2];

  regfile_read_arbiter #(.NUM_REQ(N), .RID_W(RID_W), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .req_valid(req_valid), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_ready(req_ready),
    .rf_get_id1(rf_get_id1), .rf_get_val1(rf_get_val1),
    .rf_get_has_dep1(rf_get_has_dep1), .rf_get_dep1(rf_get_dep1),
    .rf_get_id2(rf_get_id2), .rf_get_val2(rf_get_val2),
    .rf_get_has_dep2(rf_get_has_dep2), .rf_get_dep2(rf_get_dep2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rid(rsp_rid),
    .rsp_val1(rsp_val1), .rsp_has_dep1(rsp_has_dep1), .rsp_dep1(rsp_dep1),
    .rsp_val2(rsp_val2), .rsp_has_dep2(rsp_has_dep2), .rsp_dep2(rsp_dep2)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Operand lookup as the consumer should see it: x0 reads as zero, no dependency.
  function automatic logic [31:0] lk_v(input int id);
    return (id == 0) ? 32'd0 : rf_v[id];
  endfunction
  function automatic logic lk_hd(input int id);
    return (id == 0) ? 1'b0 : rf_hd[id];
  endfunction
  function automatic logic [ROB_W-1:0] lk_dp(input int id);
    return (id == 0) ? '0 : rf_dp[id];
  endfunction

  function automatic int rs_of(input logic [RSW-1:0] v, input int i);
    return int'((v >> (5 * i)) & RSW'(31));
  endfunction

  // Model state (current) and next state computed from pre-edge inputs.
  int               m_valid = 0, m_rid = 0, m_rs1 = 0, m_rs2 = 0, m_ptr = 0;
  logic [31:0]      m_v1 = '0, m_v2 = '0;
  logic             m_hd1 = 1'b0, m_hd2 = 1'b0;
  logic [ROB_W-1:0] m_d1 = '0, m_d2 = '0;
  int               n_valid = 0, n_rid = 0, n_rs1 = 0, n_rs2 = 0, n_ptr = 0;
  logic [31:0]      n_v1 = '0, n_v2 = '0;
  logic             n_hd1 = 1'b0, n_hd2 = 1'b0;
  logic [ROB_W-1:0] n_d1 = '0, n_d2 = '0;

  task automatic model_reset_next();
    n_valid = 0; n_rid = 0; n_rs1 = 0; n_rs2 = 0; n_ptr = 0;
    n_v1 = '0; n_v2 = '0; n_hd1 = 1'b0; n_hd2 = 1'b0; n_d1 = '0; n_d2 = '0;
  endtask

  // Compare process: check the DUT against the model, then work out the
  // model's state after the coming rising edge.
  always @(negedge clk_in) begin
    int          win;
    int          idx;
    int unsigned rv;
    bit          g;
    logic [N-1:0] exp_rr;
    int          e_id1, e_id2;
    if (!rst_in) begin
      check("reset rsp_valid", rsp_valid, 0);
      model_reset_next();
    end else begin
      rv  = req_valid;
      win = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && ((rv >> idx) & 1) == 1) win = idx;
      end
      g      = rdy_in && !flush_in && (m_valid == 0 || rsp_ready) && win >= 0;
      exp_rr = g ? N'(1 << win) : '0;
      e_id1  = 0;
      e_id2  = 0;
      if (g) begin
        e_id1 = rs_of(req_rs1, win);
        e_id2 = rs_of(req_rs2, win);
      end else if (rdy_in && m_valid != 0 && !rsp_ready) begin
        e_id1 = m_rs1;
        e_id2 = m_rs2;
      end
      check("req_ready", req_ready, exp_rr);
      check("rf_get_id1", rf_get_id1, e_id1);
      check("rf_get_id2", rf_get_id2, e_id2);
      check("rsp_valid", rsp_valid, m_valid);
      if (m_valid != 0) begin
        check("rsp_rid", rsp_rid, m_rid);
        check("rsp_val1", rsp_val1, m_v1);
        check("rsp_has_dep1", rsp_has_dep1, m_hd1);
        check("rsp_dep1", rsp_dep1, m_d1);
        check("rsp_val2", rsp_val2, m_v2);
        check("rsp_has_dep2", rsp_has_dep2, m_hd2);
        check("rsp_dep2", rsp_dep2, m_d2);
      end
      n_valid = m_valid; n_rid = m_rid; n_rs1 = m_rs1; n_rs2 = m_rs2; n_ptr = m_ptr;
      n_v1 = m_v1; n_hd1 = m_hd1; n_d1 = m_d1; n_v2 = m_v2; n_hd2 = m_hd2; n_d2 = m_d2;
      if (rdy_in) begin
        if (flush_in) begin
          n_valid = 0;
        end else if (g) begin
          n_valid = 1; n_rid = win; n_ptr = (win + 1) % N;
          n_rs1 = e_id1; n_rs2 = e_id2;
          n_v1 = lk_v(e_id1); n_hd1 = lk_hd(e_id1); n_d1 = lk_dp(e_id1);
          n_v2 = lk_v(e_id2); n_hd2 = lk_hd(e_id2); n_d2 = lk_dp(e_id2);
        end else if (m_valid != 0 && rsp_ready) begin
          n_valid = 0;
        end else if (m_valid != 0) begin
          n_v1 = lk_v(m_rs1); n_hd1 = lk_hd(m_rs1); n_d1 = lk_dp(m_rs1);
          n_v2 = lk_v(m_rs2); n_hd2 = lk_hd(m_rs2); n_d2 = lk_dp(m_rs2);
        end
      end
    end
  end

  always @(posedge clk_in) begin
    if (rst_in) begin
      m_valid = n_valid; m_rid = n_rid; m_rs1 = n_rs1; m_rs2 = n_rs2; m_ptr = n_ptr;
      m_v1 = n_v1; m_hd1 = n_hd1; m_d1 = n_d1; m_v2 = n_v2; m_hd2 = n_hd2; m_d2 = n_d2;
    end
  end

  always @(negedge rst_in) begin
    m_valid = 0; m_rid = 0; m_rs1 = 0; m_rs2 = 0; m_ptr = 0;
    m_v1 = '0; m_hd1 = 1'b0; m_d1 = '0; m_v2 = '0; m_hd2 = 1'b0; m_d2 = '0;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_rs(input int i, input logic [4:0] a, input logic [4:0] b);
    req_rs1[5*i +: 5] = a;
    req_rs2[5*i +: 5] = b;
  endtask

  int rr_exp [4] = '{0, 1, 2, 0};

  initial begin
    int ri;
    for (int i = 0; i < 32; i++) begin
      rf_v[i]  = $urandom;
      rf_hd[i] = 1'b0;
      rf_dp[i] = ROB_W'(i);
    end
    // x0 entry carries junk that must never reach the response.
    rf_v[0] = 32'hDEAD_BEEF; rf_hd[0] = 1'b1; rf_dp[0] = 4'hF;

    // Reset state.
    repeat (2) tick();
    check("lit reset rsp_valid", rsp_valid, 0);
    check("lit reset rsp_rid", rsp_rid, 0);
    check("lit reset rsp_val1", rsp_val1, 0);
    check("lit reset rsp_has_dep2", rsp_has_dep2, 0);
    rst_in = 1'b1;
    tick();
    check("lit idle req_ready", req_ready, 0);
    check("lit idle rf_get_id1", rf_get_id1, 0);
    check("lit idle rf_get_id2", rf_get_id2, 0);

    // Round robin with all requesters valid and the consumer always ready.
    set_rs(0, 5'd1, 5'd2); set_rs(1, 5'd3, 5'd4); set_rs(2, 5'd10, 5'd11);
    req_valid = 3'b111; rsp_ready = 1'b1;
    #1 check("lit rr first grant", req_ready, 3'b001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lit rr rsp_valid", rsp_valid, 1);
      check("lit rr rsp_rid", rsp_rid, rr_exp[i]);
    end
    req_valid = '0;

    // Single lookup; pointer is at 1 so requester 0 wins by wrapping.
    tick();
    rf_v[5] = 32'h1234; rf_hd[5] = 1'b0;
    set_rs(0, 5'd5, 5'd0);
    req_valid = 3'b001; rsp_ready = 1'b0;
    #1 check("lit single req_ready", req_ready, 3'b001);
    check("lit single rf_get_id1", rf_get_id1, 5);
    tick();
    req_valid = '0;
    #1 check("lit single rsp_valid", rsp_valid, 1);
    check("lit single rsp_rid", rsp_rid, 0);
    check("lit single rsp_val1", rsp_val1, 32'h1234);
    check("lit single rsp_val2", rsp_val2, 0);
    check("lit single rsp_has_dep2", rsp_has_dep2, 0);

    // Stall refresh: drain and grant requester 1 at the same edge.
    rf_v[7] = 32'h0; rf_hd[7] = 1'b1; rf_dp[7] = 4'd3;
    rf_v[9] = 32'h99; rf_hd[9] = 1'b0;
    set_rs(1, 5'd7, 5'd9);
    req_valid = 3'b010; rsp_ready = 1'b1;
    #1 check("lit stall grant", req_ready, 3'b010);
    tick();
    rsp_ready = 1'b0; req_valid = 3'b111;
    #1 check("lit stall rsp_rid", rsp_rid, 1);
    check("lit stall has_dep1", rsp_has_dep1, 1);
    check("lit stall dep1", rsp_dep1, 3);
    check("lit stall req_ready", req_ready, 0);
    check("lit stall rf_get_id1", rf_get_id1, 7);
    tick();
    rf_v[7] = 32'hBEEF; rf_hd[7] = 1'b0;
    #1 check("lit stall2 rf_get_id1", rf_get_id1, 7);
    tick();
    check("lit stall3 rsp_val1", rsp_val1, 32'hBEEF);
    check("lit stall3 has_dep1", rsp_has_dep1, 0);
    check("lit stall3 rsp_rid", rsp_rid, 1);
    check("lit stall3 rf_get_id1", rf_get_id1, 7);
    check("lit stall3 req_ready", req_ready, 0);
    req_valid = '0; rsp_ready = 1'b1;

    // Flush: pointer wraps 2 -> 0, grant 0, then flush with requester 1 waiting.
    tick();
    set_rs(0, 5'd3, 5'd4);
    req_valid = 3'b001; rsp_ready = 1'b0;
    tick();
    req_valid = 3'b010; flush_in = 1'b1;
    #1 check("lit flush rsp_valid before", rsp_valid, 1);
    check("lit flush req_ready", req_ready, 0);
    tick();
    flush_in = 1'b0; req_valid = 3'b111;
    #1 check("lit flush rsp_valid after", rsp_valid, 0);
    check("lit flush ptr kept", req_ready, 3'b010);
    tick();
    req_valid = '0;
    #1 check("lit flush regrant rid", rsp_rid, 1);

    // Pause: rdy_in low freezes everything.
    rdy_in = 1'b0; rsp_ready = 1'b1; req_valid = 3'b111;
    #1 check("lit pause req_ready", req_ready, 0);
    check("lit pause rf_get_id1", rf_get_id1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("lit pause rsp_valid", rsp_valid, 1);
      check("lit pause rsp_rid", rsp_rid, 1);
    end
    rdy_in = 1'b1;
    #1 check("lit resume req_ready", req_ready, 3'b100);
    tick();
    req_valid = '0;
    #1 check("lit resume rsp_rid", rsp_rid, 2);

    // Randomized phase against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rdy_in    = ($urandom % 8) != 0;
      flush_in  = ($urandom % 16) == 0;
      req_valid = N'($urandom);
      req_rs1   = RSW'($urandom);
      req_rs2   = RSW'($urandom);
      if ($urandom % 4 == 0) set_rs(int'($urandom % N), 5'd0, 5'd0);
      rsp_ready = ($urandom % 3) != 0;
      ri = int'($urandom % 32);
      rf_v[ri]  = $urandom;
      rf_hd[ri] = 1'($urandom);
      rf_dp[ri] = ROB_W'($urandom);
    end

    // Asynchronous reset with a response held.
    tick();
    rdy_in = 1'b1; flush_in = 1'b0; rsp_ready = 1'b0; req_valid = 3'b001;
    tick();
    req_valid = '0;
    #1 check("lit pre-reset rsp_valid", rsp_valid, 1);
    rst_in = 1'b0;
    #1 check("lit async reset rsp_valid", rsp_valid, 0);
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    check("lit post-reset rsp_valid", rsp_valid, 0);
    check("lit post-reset req_ready", req_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
